// File: rtl/cipher_stream_ctrl.sv
// Serial block-cipher controller: W-bit deserialiser, key whitening plus NR
// one-cycle rounds, and a ready/valid serialiser with one block of input buffering.
module cipher_stream_ctrl #(
    parameter int W  = 1,
    parameter int NB = 16,
    parameter int NR = 10
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic [W-1:0] din,
    input  logic [W-1:0] kin,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         block_done
);

    localparam int NBITS = NB * 8;
    localparam int BEATS = NBITS / W;
    localparam int CW    = $clog2(BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NBITS-1:0] r_d;
    logic [NBITS-1:0] r_k;
    logic [NBITS-1:0] r_s;
    logic [NBITS-1:0] r_kr;
    logic [NBITS-1:0] w_round;
    logic [NBITS-1:0] w_out_sh;
    logic [CW-1:0]    r_icnt;
    logic [CW-1:0]    r_ocnt;
    logic [3:0]       r_rc;
    logic             r_pending;
    logic             r_mode_in;
    logic             r_m;
    logic             w_in_fire;
    logic             w_in_last;
    logic             w_out_fire;
    logic             w_out_last;
    logic             w_load;

    // Byte 0 is the first byte streamed, so it sits in the top bits.
    function automatic logic [7:0] f_byte(input logic [NBITS-1:0] v, input int unsigned i);
        return v[(NB-1-i)*8 +: 8];
    endfunction

    function automatic logic [7:0] f_rotl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [7:0] f_rotr(input logic [7:0] b);
        return {b[0], b[7:1]};
    endfunction

    assign in_ready  = !r_pending;
    assign w_in_fire = in_valid && !r_pending;
    assign w_in_last = (r_icnt == CW'(BEATS - 1));

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_d       <= '0;
            r_k       <= '0;
            r_icnt    <= '0;
            r_pending <= 1'b0;
            r_mode_in <= 1'b0;
        end else if (w_in_fire) begin
            r_d <= {r_d[NBITS-W-1:0], din};
            r_k <= {r_k[NBITS-W-1:0], kin};
            if (w_in_last) begin
                r_icnt    <= '0;
                r_pending <= 1'b1;
                r_mode_in <= mode;
            end else begin
                r_icnt <= r_icnt + 1'b1;
            end
        end else if (w_load) begin
            r_pending <= 1'b0;
        end
    end

    always_comb begin
        w_round = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (!r_m)
                w_round[(NB-1-i)*8 +: 8] = f_rotl(f_byte(r_s, (i + 1) % NB)) ^ f_byte(r_kr, i);
            else
                w_round[(NB-1-i)*8 +: 8] = f_rotr(f_byte(r_s, (i + NB - 1) % NB)
                                                  ^ f_byte(r_kr, (i + NB - 1) % NB));
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // The OUT exit reuses the IDLE load so a pending block starts with no idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        out_valid   = 1'b0;
        w_out_fire  = 1'b0;
        w_out_last  = (r_ocnt == CW'(BEATS - 1));
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_rc == 4'(NR - 1)) w_state_nxt = S_FINAL;
            end
            S_FINAL: w_state_nxt = S_OUT;
            S_OUT: begin
                out_valid  = 1'b1;
                w_out_fire = out_ready;
                if (out_ready && w_out_last) begin
                    if (r_pending) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ROUND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_s    <= '0;
            r_kr   <= '0;
            r_m    <= 1'b0;
            r_rc   <= '0;
            r_ocnt <= '0;
        end else begin
            if (w_load) begin
                r_s  <= r_mode_in ? r_d : (r_d ^ r_k);
                r_kr <= r_k;
                r_m  <= r_mode_in;
                r_rc <= '0;
            end else if (r_state == S_ROUND) begin
                r_s  <= w_round;
                r_rc <= r_rc + 1'b1;
            end else if (r_state == S_FINAL && r_m) begin
                r_s <= r_s ^ r_kr;
            end
            if (w_out_fire) r_ocnt <= w_out_last ? '0 : r_ocnt + 1'b1;
        end
    end

    assign w_out_sh   = r_s << (32'(r_ocnt) * W);
    assign dout       = out_valid ? w_out_sh[NBITS-1 -: W] : '0;
    assign block_done = w_out_fire && w_out_last;
    assign busy       = r_pending || (r_state != S_IDLE);

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Scoreboard bench for cipher_stream_ctrl: three instances (W=8/NB=4/NR=1,
// W=1/NB=16/NR=10, W=4/NB=4/NR=1) checked beat by beat against a reference model.
module tb_cipher_stream_ctrl;

    logic clk;
    logic rst;
    logic bp;

    logic [7:0] a_din, a_kin, a_dout;
    logic       a_mode, a_iv, a_ir, a_ov, a_ordy, a_busy, a_bd;
    logic [0:0] b_din, b_kin, b_dout;
    logic       b_mode, b_iv, b_ir, b_ov, b_ordy, b_busy, b_bd;
    logic [3:0] c_din, c_kin, c_dout;
    logic       c_mode, c_iv, c_ir, c_ov, c_ordy, c_busy, c_bd;

    int n_vec = 0;
    int n_mis = 0;

    logic [255:0] q0[$];
    logic [255:0] q1[$];
    logic [255:0] q2[$];
    logic [255:0] cur[3];
    logic         have[3];
    int           idx[3];
    string        nm[3] = '{"A", "B", "C"};

    cipher_stream_ctrl #(.W(8), .NB(4), .NR(1)) u_a (
        .clock(clk), .Reset(rst), .din(a_din), .kin(a_kin), .mode(a_mode),
        .in_valid(a_iv), .in_ready(a_ir), .dout(a_dout), .out_valid(a_ov),
        .out_ready(a_ordy), .busy(a_busy), .block_done(a_bd)
    );

    cipher_stream_ctrl #(.W(1), .NB(16), .NR(10)) u_b (
        .clock(clk), .Reset(rst), .din(b_din), .kin(b_kin), .mode(b_mode),
        .in_valid(b_iv), .in_ready(b_ir), .dout(b_dout), .out_valid(b_ov),
        .out_ready(b_ordy), .busy(b_busy), .block_done(b_bd)
    );

    cipher_stream_ctrl #(.W(4), .NB(4), .NR(1)) u_c (
        .clock(clk), .Reset(rst), .din(c_din), .kin(c_kin), .mode(c_mode),
        .in_valid(c_iv), .in_ready(c_ir), .dout(c_dout), .out_valid(c_ov),
        .out_ready(c_ordy), .busy(c_busy), .block_done(c_bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int s);
        return (s == 0) ? 8 : (s == 1) ? 1 : 4;
    endfunction

    function automatic int beats(input int s);
        return (s == 0) ? 4 : (s == 1) ? 128 : 8;
    endfunction

    function automatic logic f_ir(input int s);
        return (s == 0) ? a_ir : (s == 1) ? b_ir : c_ir;
    endfunction

    function automatic logic f_ov(input int s);
        return (s == 0) ? a_ov : (s == 1) ? b_ov : c_ov;
    endfunction

    function automatic logic f_ordy(input int s);
        return (s == 0) ? a_ordy : (s == 1) ? b_ordy : c_ordy;
    endfunction

    function automatic logic f_busy(input int s);
        return (s == 0) ? a_busy : (s == 1) ? b_busy : c_busy;
    endfunction

    function automatic logic f_bd(input int s);
        return (s == 0) ? a_bd : (s == 1) ? b_bd : c_bd;
    endfunction

    function automatic logic [7:0] f_dout(input int s);
        return (s == 0) ? a_dout : (s == 1) ? {7'd0, b_dout} : {4'd0, c_dout};
    endfunction

    // Blocks are held left-aligned: byte 0 in [255:248]; beat j is the j-th W-bit slice from the top.
    function automatic logic [7:0] f_beat(input logic [255:0] v, input int j, input int w);
        logic [255:0] t;
        t = v << (j * w);
        return t[255:248] >> (8 - w);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] b);
        return {b[0], b[7:1]};
    endfunction

    function automatic logic [255:0] f_model(input logic [255:0] d, input logic [255:0] k,
                                             input logic m, input int nb, input int nr);
        logic [7:0]   s[32];
        logic [7:0]   kb[32];
        logic [7:0]   t[32];
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            s[i] = '0; kb[i] = '0; t[i] = '0;
        end
        for (int i = 0; i < nb; i++) begin
            s[i]  = d[255-8*i -: 8];
            kb[i] = k[255-8*i -: 8];
            if (!m) s[i] = s[i] ^ kb[i];
        end
        for (int n = 0; n < nr; n++) begin
            for (int i = 0; i < nb; i++) begin
                if (!m) t[i] = rotl(s[(i + 1) % nb]) ^ kb[i];
                else    t[i] = rotr(s[(i + nb - 1) % nb] ^ kb[(i + nb - 1) % nb]);
            end
            for (int i = 0; i < nb; i++) s[i] = t[i];
        end
        r = '0;
        for (int i = 0; i < nb; i++) r[255-8*i -: 8] = m ? (s[i] ^ kb[i]) : s[i];
        return r;
    endfunction

    function automatic logic [255:0] rnd(input int nb);
        logic [255:0] r;
        logic [255:0] msk;
        r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        msk = '1;
        msk = ~(msk >> (nb * 8));
        return r & msk;
    endfunction

    task automatic q_push(input int s, input logic [255:0] v);
        case (s)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int s);
        return (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
    endfunction

    task automatic q_pop(input int s, output logic [255:0] v);
        case (s)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] dv, input logic [7:0] kv,
                         input logic m);
        case (s)
            0: begin a_iv = v; a_din = dv;      a_kin = kv;      a_mode = m; end
            1: begin b_iv = v; b_din = dv[0];   b_kin = kv[0];   b_mode = m; end
            default: begin c_iv = v; c_din = dv[3:0]; c_kin = kv[3:0]; c_mode = m; end
        endcase
    endtask

    // Called at a point where in_ready is stable; returns #1 after the completing edge.
    task automatic send(input int s, input logic [255:0] d, input logic [255:0] k, input logic m,
                        input logic [255:0] exp);
        logic r;
        logic ok;
        for (int j = 0; j < beats(s); j++) begin
            drive(s, 1'b1, f_beat(d, j, wid(s)), f_beat(k, j, wid(s)), m);
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                r = f_ir(s);
                @(posedge clk);
                #1;
                ok = r;
            end
            if (!ok) chk({nm[s], ".in_ready_timeout"}, 0, 1);
        end
        drive(s, 1'b0, 8'd0, 8'd0, 1'b0);
        q_push(s, exp);
    endtask

    task automatic wait_idle(input int s);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = (q_size(s) == 0) && !have[s] && !f_busy(s);
        end
        if (!ok) chk({nm[s], ".drain_timeout"}, 0, 1);
    endtask

    task automatic mon(input int s);
        logic v;
        logic r;
        logic last;
        if (rst) begin
            have[s] = 1'b0;
            case (s)
                0: q0.delete();
                1: q1.delete();
                default: q2.delete();
            endcase
        end else begin
            v = f_ov(s);
            r = f_ordy(s);
            if (v && !have[s]) begin
                if (q_size(s) == 0) begin
                    chk({nm[s], ".unexpected_out_valid"}, v, 0);
                end else begin
                    q_pop(s, cur[s]);
                    have[s] = 1'b1;
                    idx[s]  = 0;
                end
            end
            if (v && have[s]) begin
                last = (idx[s] == beats(s) - 1);
                chk({nm[s], ".dout"}, f_dout(s), f_beat(cur[s], idx[s], wid(s)));
                chk({nm[s], ".block_done"}, f_bd(s), r && last);
                if (r) begin
                    if (last) have[s] = 1'b0;
                    else      idx[s]++;
                end
            end else if (have[s]) begin
                chk({nm[s], ".out_valid_held"}, v, 1);
            end else begin
                chk({nm[s], ".block_done_idle"}, f_bd(s), 0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) mon(s);
    end

    initial begin
        a_ordy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_ordy = bp ? ~a_ordy : 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] d, k, e, d2, k2;
        logic         m, hit;
        int           cnt;
        logic         done;

        rst = 1'b1;
        bp  = 1'b0;
        b_ordy = 1'b1;
        c_ordy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            have[s] = 1'b0;
            idx[s]  = 0;
            cur[s]  = '0;
            drive(s, 1'b0, 8'd0, 8'd0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk({nm[s], ".rst_in_ready"}, f_ir(s), 1);
            chk({nm[s], ".rst_out_valid"}, f_ov(s), 0);
            chk({nm[s], ".rst_dout"}, f_dout(s), 0);
            chk({nm[s], ".rst_busy"}, f_busy(s), 0);
            chk({nm[s], ".rst_block_done"}, f_bd(s), 0);
        end
        @(posedge clk);
        #1;

        // Known encrypt vector, with latency and in_ready timing around the load.
        send(0, {32'h00010203, 224'd0}, {32'h10203040, 224'd0}, 1'b0, {32'h5244B660, 224'd0});
        cnt  = 0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (cnt == 0) begin
                chk("A.in_ready_after_last", a_ir, 0);
                chk("A.busy_pending", a_busy, 1);
            end
            if (cnt == 1) chk("A.in_ready_after_load", a_ir, 1);
            if (a_ov) done = 1'b1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
        chk("A.first_out_latency", cnt, 3);
        wait_idle(0);

        send(0, {32'h5244B660, 224'd0}, {32'h10203040, 224'd0}, 1'b1, {32'h00010203, 224'd0});
        wait_idle(0);

        for (int n = 0; n < 3; n++) begin
            d = rnd(4);
            k = rnd(4);
            m = 1'($urandom_range(0, 1));
            send(0, d, k, m, f_model(d, k, m, 4, 1));
        end
        wait_idle(0);

        // Back-to-back blocks under alternating out_ready.
        bp = 1'b1;
        d  = rnd(4);
        k  = rnd(4);
        d2 = rnd(4);
        k2 = rnd(4);
        send(0, d, k, 1'b0, f_model(d, k, 1'b0, 4, 1));
        send(0, d2, k2, 1'b1, f_model(d2, k2, 1'b1, 4, 1));
        @(negedge clk);
        chk("A.in_ready_while_pending", a_ir, 0);
        chk("A.busy_while_pending", a_busy, 1);
        @(posedge clk);
        #1;
        d = rnd(4);
        k = rnd(4);
        send(0, d, k, 1'b0, f_model(d, k, 1'b0, 4, 1));
        wait_idle(0);
        bp = 1'b0;

        // Reset while the second output beat is on the bus.
        d = rnd(4);
        k = rnd(4);
        send(0, d, k, 1'b0, f_model(d, k, 1'b0, 4, 1));
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(posedge clk);
            #1;
            hit = have[0] && (idx[0] == 1);
        end
        chk("A.reach_second_beat", hit, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("A.post_rst_out_valid", a_ov, 0);
        chk("A.post_rst_busy", a_busy, 0);
        chk("A.post_rst_in_ready", a_ir, 1);
        @(posedge clk);
        #1;
        d = rnd(4);
        k = rnd(4);
        send(0, d, k, 1'b1, f_model(d, k, 1'b1, 4, 1));
        wait_idle(0);

        // Serial round trip at W=1.
        d = rnd(16);
        k = rnd(16);
        e = f_model(d, k, 1'b0, 16, 10);
        send(1, d, k, 1'b0, e);
        send(1, e, k, 1'b1, d);
        wait_idle(1);

        // W=4 nibble ordering: decrypt yields A5 as byte 0, so beats A then 5 lead.
        d = rnd(4);
        d[255:248] = 8'hA5;
        k = rnd(4);
        e = f_model(d, k, 1'b0, 4, 1);
        send(2, d, k, 1'b0, e);
        send(2, e, k, 1'b1, d);
        wait_idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
